alu_serial_seq: RTL and testbench

- Multi-cycle sequencer that drives the 1-bit ALU slice datapath (AND/OR/ADD/SUB/SLT, selected by MIPS funct code) as a bit-serial ALU.
- Accepts one operation plus two WIDTH-bit operands over a valid/ready handshake.
- Steps the slice logic BPC bits per clock, carrying the ripple carry between steps, and resolves SLT in a dedicated final state.
- Returns result, zero and overflow over a second valid/ready handshake; sits between the control unit and the register write-back path.

---
 rtl/alu_serial_seq.sv | 147 ++++++++++++++
 tb/tb_alu_serial_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: steps the AND/OR/ADD/SUB/SLT slice BPC bits per clock with registered ripple carry.
// Optional NOR (funct 39) is enabled by defining ALU_SEQ_NOR_EN; without it funct 39 takes the error path.
module alu_serial_seq #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int N  = WIDTH / BPC;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  generate
    if (WIDTH % BPC != 0) begin : g_bpc_check
      $error("alu_serial_seq: BPC must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, SETL, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, res_nxt;
  logic             carry, ovf_raw, ovf_q, err_q;
  logic [SW-1:0]    step;
  logic [BPC-1:0]   bits;
  logic             cin_msb, cout_msb;
  logic             is_logic, is_slt, inv, last_step;

  function automatic logic supported(input logic [5:0] f);
    case (f)
      6'd32, 6'd34, 6'd36, 6'd37, 6'd42: return 1'b1;
`ifdef ALU_SEQ_NOR_EN
      6'd39: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Only funct[3:0] is needed once the request has been qualified as supported.
  assign is_logic  = op[2];
  assign is_slt    = ~op[2] & op[3];
  assign inv       = ~op[2] & op[1];
  assign last_step = (step == LAST);

  always_comb begin
    logic c, ai, bi, lg;
    c       = carry;
    cin_msb = 1'b0;
    bits    = '0;
    for (int i = 0; i < BPC; i++) begin
      ai = a_sh[i];
      bi = b_sh[i] ^ inv;
      if (i == BPC - 1) cin_msb = c;
      lg = op[0] ? (ai | bi) : (ai & bi);
`ifdef ALU_SEQ_NOR_EN
      if (op[1:0] == 2'b11) lg = ~(ai | bi);
`endif
      bits[i] = is_logic ? lg : (ai ^ bi ^ c);
      c = (ai & bi) | (ai & c) | (bi & c);
    end
    cout_msb = c;
    res_nxt  = WIDTH'({bits, res_q} >> BPC);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) state_nxt = supported(funct) ? RUN : DONE;
      RUN:  if (last_step) state_nxt = is_slt ? SETL : DONE;
      SETL: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_q   <= '0;
      carry   <= 1'b0;
      step    <= '0;
      ovf_raw <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op      <= funct[3:0];
          a_sh    <= a;
          b_sh    <= b;
          res_q   <= '0;
          step    <= '0;
          ovf_raw <= 1'b0;
          ovf_q   <= 1'b0;
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          carry   <= supported(funct) & ~funct[2] & funct[1];
          err_q   <= ~supported(funct);
        end
        RUN: begin
          a_sh  <= a_sh >> BPC;
          b_sh  <= b_sh >> BPC;
          res_q <= res_nxt;
          carry <= cout_msb;
          step  <= step + 1'b1;
          if (last_step) begin
            ovf_raw <= cin_msb ^ cout_msb;
            ovf_q   <= (cin_msb ^ cout_msb) & ~is_logic & ~is_slt;
          end
        end
        SETL: begin
          res_q <= WIDTH'(res_q[WIDTH-1] ^ ovf_raw);
          ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result = res_q;
  assign zero   = out_valid && (res_q == '0);
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench: drives BPC=1 and BPC=4 sequencers in lockstep, checks results and latency against an arithmetic model.
module tb_alu_serial_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [5:0] funct;
  logic [W-1:0] a, b;
  logic i_rdy1, o_vld1, zer1, ovf1, err1, ordy1;
  logic i_rdy4, o_vld4, zer4, ovf4, err4, ordy4;
  logic [W-1:0] res1, res4;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W), .BPC(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i_rdy1), .funct(funct), .a(a), .b(b),
    .out_valid(o_vld1), .out_ready(ordy1), .result(res1), .zero(zer1), .ovf(ovf1), .err(err1));

  alu_serial_seq #(.WIDTH(W), .BPC(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i_rdy4), .funct(funct), .a(a), .b(b),
    .out_valid(o_vld4), .out_ready(ordy4), .result(res4), .zero(zer4), .ovf(ovf4), .err(err4));

  typedef struct {
    logic [31:0] res;
    logic        zero, ovf, err;
    int          lat, acc, hold;
  } exp_t;

  exp_t q1[$], q4[$];
  exp_t cur[2];
  logic act[2];
  int   hold[2];
  int   tests, fails, cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input int n);
    exp_t e;
    e.res = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = n + 1; e.acc = 0; e.hold = 0;
    case (f)
      6'd32: begin e.res = x + y; e.ovf = (x[31] == y[31]) && (e.res[31] != x[31]); end
      6'd34: begin e.res = x - y; e.ovf = (x[31] != y[31]) && (e.res[31] != x[31]); end
      6'd36: e.res = x & y;
      6'd37: e.res = x | y;
      6'd42: begin e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; e.lat = n + 2; end
`ifdef ALU_SEQ_NOR_EN
      6'd39: e.res = ~(x | y);
`endif
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic mon(input int k, input logic vld, input logic rdy, input logic [31:0] r,
                     input logic z, input logic o, input logic e, output logic ordy);
    string t;
    t = (k == 0) ? "bpc1" : "bpc4";
    ordy = 1'($urandom_range(0, 1));
    if (!vld) begin
      act[k] = 1'b0;
      return;
    end
    check($sformatf("%s in_ready_in_done", t), {31'd0, rdy}, 32'd0);
    if (!act[k]) begin
      if ((k == 0 && q1.size() == 0) || (k == 1 && q4.size() == 0)) begin
        check($sformatf("%s unexpected_out_valid", t), {31'd0, vld}, 32'd0);
        return;
      end
      cur[k] = (k == 0) ? q1.pop_front() : q4.pop_front();
      check($sformatf("%s latency", t), 32'(cyc - cur[k].acc), 32'(cur[k].lat));
      act[k]  = 1'b1;
      hold[k] = cur[k].hold;
    end
    check($sformatf("%s result", t), r, cur[k].res);
    check($sformatf("%s zero", t), {31'd0, z}, {31'd0, cur[k].zero});
    check($sformatf("%s ovf", t), {31'd0, o}, {31'd0, cur[k].ovf});
    check($sformatf("%s err", t), {31'd0, e}, {31'd0, cur[k].err});
    if (hold[k] > 0) begin
      hold[k]--;
      ordy = 1'b0;
    end else begin
      ordy = ($urandom_range(0, 3) != 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, o_vld1, i_rdy1, res1, zer1, ovf1, err1, ordy1);
    mon(1, o_vld4, i_rdy4, res4, zer4, ovf4, err4, ordy4);
  end

  // Issues one request to both DUTs; an extra in_valid cycle with junk data must be ignored while busy.
  task automatic drive(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       input int h1, input int h4, input bit push1);
    exp_t e;
    int t = 0;
    while (!(i_rdy1 && i_rdy4) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("ready_timeout", 32'd0, 32'd1);
    if (push1) begin
      e = model(f, x, y, 32); e.acc = cyc; e.hold = h1; q1.push_back(e);
    end
    e = model(f, x, y, 8); e.acc = cyc; e.hold = h4; q4.push_back(e);
    in_valid = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    funct = 6'd32; a = $urandom; b = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 8))
      0, 1: return 6'd32;
      2:    return 6'd34;
      3:    return 6'd36;
      4:    return 6'd37;
      5, 6: return 6'd42;
      7:    return 6'd39;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; funct = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", {30'd0, i_rdy1, i_rdy4}, 32'd3);
    check("reset out_valid", {30'd0, o_vld1, o_vld4}, 32'd0);
    check("reset result", res1 | res4, 32'd0);
    check("reset flags", {26'd0, zer1, ovf1, err1, zer4, ovf4, err4}, 32'd0);

    drive(6'd32, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1);
    drive(6'd34, 32'd5, 32'd5, 0, 0, 1);
    drive(6'd42, 32'hFFFF_FFFF, 32'd1, 0, 0, 1);
    drive(6'd42, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 1);
    drive(6'd42, 32'd3, 32'd2, 0, 0, 1);
    drive(6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00, 10, 10, 1);
    drive(6'd37, 32'hF0F0_F0F0, 32'hFF00_FF00, 10, 10, 1);
    drive(6'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1);
    drive(6'd39, 32'd0, 32'd0, 0, 0, 1);

    // Abort the BPC=1 unit at step 10; the BPC=4 unit is already parked in DONE by then.
    drive(6'd32, 32'h0001_2345, 32'h0006_7890, 0, 30, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", {30'd0, i_rdy1, i_rdy4}, 32'd3);
    check("abort out_valid", {30'd0, o_vld1, o_vld4}, 32'd0);
    check("abort result", res1 | res4, 32'd0);
    drive(6'd32, 32'd2, 32'd3, 0, 0, 1);

    for (int i = 0; i < 150; i++)
      drive(pick_funct(), pick_op(), pick_op(), $urandom_range(0, 3), $urandom_range(0, 3), 1);

    t = 0;
    while ((q1.size() != 0 || q4.size() != 0 || o_vld1 || o_vld4) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("drain_timeout", 32'(q1.size() + q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
